// File: rtl/xvga_timing.sv
// xvga_timing: 1024x768@60 Hz raster generator for the 65 MHz pixel clock.
// Produces zero-latency counts and sync/blank decodes for the renderer, then
// re-aligns the renderer's pixel with syncs/blank delayed by LATENCY stages
// so that colour and timing reach the DAC on the same registered edge.
// LATENCY is legal over 0..4.

module xvga_timing #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter int LATENCY  = 1
) (
  input  logic        vclock,
  input  logic        reset_n,
  input  logic [23:0] pixel_in,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        frame_start,
  output logic [15:0] frame_count,
  output logic [23:0] rgb_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_STOP  = HS_START + H_SYNC;   // first count after the pulse
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_STOP  = VS_START + V_SYNC;

  logic       h_wrap;
  logic       v_wrap;
  logic [2:0] live_bits;   // {hsync, vsync, blank} for the current counts
  logic [2:0] tap;         // the same bits as seen LATENCY cycles ago

  // End-of-line and end-of-frame detection from the count registers.
  always_comb begin
    h_wrap = (hcount == 11'(H_TOTAL - 1));
    v_wrap = (vcount == 10'(V_TOTAL - 1));
  end

  // Raster counters; the frame counter steps on the double-wrap edge and wraps silently.
  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      hcount      <= 11'd0;
      vcount      <= 10'd0;
      frame_count <= 16'd0;
    end else if (h_wrap) begin
      hcount <= 11'd0;
      if (v_wrap) begin
        vcount      <= 10'd0;
        frame_count <= frame_count + 16'd1;
      end else begin
        vcount <= vcount + 10'd1;
      end
    end else begin
      hcount <= hcount + 11'd1;
    end
  end

  // Zero-latency sync, blank and frame-start decodes of the current position.
  always_comb begin
    hsync       = !((hcount >= 11'(HS_START)) && (hcount < 11'(HS_STOP)));
    vsync       = !((vcount >= 10'(VS_START)) && (vcount < 10'(VS_STOP)));
    blank       = (hcount >= 11'(H_ACTIVE)) || (vcount >= 10'(V_ACTIVE));
    frame_start = (hcount == 11'd0) && (vcount == 10'd0);
    live_bits   = {hsync, vsync, blank};
  end

  generate
    if (LATENCY == 0) begin : g_no_delay
      assign tap = live_bits;
    end else begin : g_delay
      logic [2:0] dly [LATENCY];

      // Delay line matching the renderer latency; reset flushes it to idle so
      // no partial sync pulse survives a mid-frame reset.
      always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < LATENCY; i++) begin
            dly[i] <= 3'b111;
          end
        end else begin
          dly[0] <= live_bits;
          for (int i = 1; i < LATENCY; i++) begin
            dly[i] <= dly[i - 1];
          end
        end
      end

      assign tap = dly[LATENCY - 1];
    end
  endgenerate

  // Display output register: colour forced to black whenever the aligned blank is set.
  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      rgb_out   <= 24'h000000;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      blank_out <= 1'b1;
    end else begin
      rgb_out   <= tap[0] ? 24'h000000 : pixel_in;
      hsync_out <= tap[2];
      vsync_out <= tap[1];
      blank_out <= tap[0];
    end
  end

endmodule

// File: tb/tb_xvga_timing.sv
// Bench for xvga_timing: one default-timing instance (LATENCY=1) and two
// reduced-timing instances (LATENCY=0 and LATENCY=4) sharing clock and reset.
// The stimulus process advances a reference raster and queues expected
// outputs; a negedge monitor pops and compares one entry per cycle.

module tb_xvga_timing;

  localparam int SHA = 16, SHF = 2, SHS = 3, SHB = 4;   // small H timing, total 25
  localparam int SVA = 6,  SVF = 1, SVS = 2, SVB = 2;   // small V timing, total 11
  localparam int STH = SHA + SHF + SHS + SHB;
  localparam int STV = SVA + SVF + SVS + SVB;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        fs;
    logic [15:0] fc;
  } live_t;

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        bl;
  } pipe_t;

  logic vclock = 1'b0;
  logic reset_n;
  logic run;
  logic [23:0] pixel_a;
  logic [23:0] pixel_s;

  logic [10:0] hcount_a, hcount_b, hcount_c;
  logic [9:0]  vcount_a, vcount_b, vcount_c;
  logic        hsync_a, vsync_a, blank_a, fs_a;
  logic        hsync_b, vsync_b, blank_b, fs_b;
  logic        hsync_c, vsync_c, blank_c, fs_c;
  logic [15:0] fc_a, fc_b, fc_c;
  logic [23:0] rgb_a, rgb_b, rgb_c;
  logic        hso_a, vso_a, blo_a;
  logic        hso_b, vso_b, blo_b;
  logic        hso_c, vso_c, blo_c;

  int checks;
  int failures;
  int hs_low_a;
  int fs_cnt_s;

  int ah, av, afc, aph, apv;
  int sh, sv, sfc;

  live_t q_la[$];
  live_t q_ls[$];
  pipe_t q_pa[$];
  pipe_t q_pb[$];
  pipe_t q_pc[$];

  always #5 vclock = ~vclock;

  assign pixel_s = 24'hFFFF00;

  xvga_timing dut_a (
    .vclock(vclock), .reset_n(reset_n), .pixel_in(pixel_a),
    .hcount(hcount_a), .vcount(vcount_a), .hsync(hsync_a), .vsync(vsync_a),
    .blank(blank_a), .frame_start(fs_a), .frame_count(fc_a),
    .rgb_out(rgb_a), .hsync_out(hso_a), .vsync_out(vso_a), .blank_out(blo_a)
  );

  xvga_timing #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .LATENCY(0)
  ) dut_b (
    .vclock(vclock), .reset_n(reset_n), .pixel_in(pixel_s),
    .hcount(hcount_b), .vcount(vcount_b), .hsync(hsync_b), .vsync(vsync_b),
    .blank(blank_b), .frame_start(fs_b), .frame_count(fc_b),
    .rgb_out(rgb_b), .hsync_out(hso_b), .vsync_out(vso_b), .blank_out(blo_b)
  );

  xvga_timing #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .LATENCY(4)
  ) dut_c (
    .vclock(vclock), .reset_n(reset_n), .pixel_in(pixel_s),
    .hcount(hcount_c), .vcount(vcount_c), .hsync(hsync_c), .vsync(vsync_c),
    .blank(blank_c), .frame_start(fs_c), .frame_count(fc_c),
    .rgb_out(rgb_c), .hsync_out(hso_c), .vsync_out(vso_c), .blank_out(blo_c)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic live_t mk_live(input int h, input int v, input int fc,
                                    input int ha, input int hf, input int hs,
                                    input int va, input int vf, input int vs);
    live_t e;
    e.h  = 11'(h);
    e.v  = 10'(v);
    e.hs = !((h >= ha + hf) && (h < ha + hf + hs));
    e.vs = !((v >= va + vf) && (v < va + vf + vs));
    e.bl = (h >= ha) || (v >= va);
    e.fs = (h == 0) && (v == 0);
    e.fc = 16'(fc);
    return e;
  endfunction

  function automatic pipe_t mk_pipe(input live_t l, input logic [23:0] pix);
    pipe_t p;
    p.rgb = l.bl ? 24'h000000 : pix;
    p.hs  = l.hs;
    p.vs  = l.vs;
    p.bl  = l.bl;
    return p;
  endfunction

  function automatic pipe_t mk_idle();
    pipe_t p;
    p.rgb = 24'h000000;
    p.hs  = 1'b1;
    p.vs  = 1'b1;
    p.bl  = 1'b1;
    return p;
  endfunction

  task automatic push_all();
    live_t la;
    live_t ls;
    la = mk_live(ah, av, afc, 1024, 24, 136, 768, 3, 6);
    ls = mk_live(sh, sv, sfc, SHA, SHF, SHS, SVA, SVF, SVS);
    q_la.push_back(la);
    q_pa.push_back(mk_pipe(la, {3'b000, 11'(ah), 10'(av)}));
    q_ls.push_back(ls);
    q_pb.push_back(mk_pipe(ls, 24'hFFFF00));
    q_pc.push_back(mk_pipe(ls, 24'hFFFF00));
  endtask

  // One clock of stimulus: advance the reference raster, queue expectations,
  // and present the renderer pixel for the previous cycle's counts.
  task automatic step(input bit force_fc);
    @(posedge vclock);
    #1;
    aph = ah;
    apv = av;
    if (ah == 1343) begin
      ah = 0;
      if (av == 805) begin
        av  = 0;
        afc = (afc + 1) % 65536;
      end else begin
        av++;
      end
    end else begin
      ah++;
    end
    if (sh == STH - 1) begin
      sh = 0;
      if (sv == STV - 1) begin
        sv  = 0;
        sfc = (sfc + 1) % 65536;
      end else begin
        sv++;
      end
    end else begin
      sh++;
    end
    if (force_fc) begin
      force dut_b.frame_count = 16'hFFFF;
      force dut_c.frame_count = 16'hFFFF;
      sfc = 65535;
    end
    push_all();
    pixel_a = {3'b000, 11'(aph), 10'(apv)};
    if (force_fc) begin
      #1;
      release dut_b.frame_count;
      release dut_c.frame_count;
    end
  endtask

  task automatic release_reset();
    @(posedge vclock);
    #1;
    reset_n = 1'b1;
    ah = 0; av = 0; afc = 0; aph = 0; apv = 0;
    sh = 0; sv = 0; sfc = 0;
    q_la.delete(); q_ls.delete(); q_pa.delete(); q_pb.delete(); q_pc.delete();
    repeat (2) q_pa.push_back(mk_idle());
    repeat (1) q_pb.push_back(mk_idle());
    repeat (5) q_pc.push_back(mk_idle());
    push_all();
    pixel_a  = 24'h000000;
    hs_low_a = 0;
    fs_cnt_s = 0;
    run      = 1'b1;
  endtask

  // Monitor: pop one expected entry per instance each cycle and compare.
  always @(negedge vclock) begin
    live_t ea, es;
    pipe_t pa, pb, pc;
    if (run) begin
      if (q_la.size() == 0 || q_ls.size() == 0 || q_pa.size() == 0 ||
          q_pb.size() == 0 || q_pc.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow actual=empty required=entry at %0t", $time);
      end else begin
        ea = q_la.pop_front();
        es = q_ls.pop_front();
        pa = q_pa.pop_front();
        pb = q_pb.pop_front();
        pc = q_pc.pop_front();
        chk("live_a", 64'({hcount_a, vcount_a, hsync_a, vsync_a, blank_a, fs_a, fc_a}), 64'(ea));
        chk("live_b", 64'({hcount_b, vcount_b, hsync_b, vsync_b, blank_b, fs_b, fc_b}), 64'(es));
        chk("live_c", 64'({hcount_c, vcount_c, hsync_c, vsync_c, blank_c, fs_c, fc_c}), 64'(es));
        chk("pipe_a", 64'({rgb_a, hso_a, vso_a, blo_a}), 64'(pa));
        chk("pipe_b", 64'({rgb_b, hso_b, vso_b, blo_b}), 64'(pb));
        chk("pipe_c", 64'({rgb_c, hso_c, vso_c, blo_c}), 64'(pc));
      end
      if (!hsync_a) hs_low_a++;
      if (fs_b) fs_cnt_s++;
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    run      = 1'b0;
    reset_n  = 1'b0;
    pixel_a  = 24'h000000;
    repeat (3) @(posedge vclock);
    release_reset();

    // Run to hcount=500 on an active line, then reset asynchronously mid-line.
    repeat (500) step(1'b0);
    run = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_hcount",    64'(hcount_a), 64'd0);
    chk("rst_vcount",    64'(vcount_a), 64'd0);
    chk("rst_fcount",    64'(fc_a),     64'd0);
    chk("rst_rgb_out",   64'(rgb_a),    64'd0);
    chk("rst_hsync_out", 64'(hso_a),    64'd1);
    chk("rst_vsync_out", 64'(vso_a),    64'd1);
    chk("rst_blank_out", 64'(blo_a),    64'd1);
    chk("rst_pipe_c",    64'({rgb_c, hso_c, vso_c, blo_c}), 64'h7);
    repeat (4) @(posedge vclock);
    #1;
    chk("rst_hold_hcount", 64'(hcount_a), 64'd0);
    release_reset();

    // Exactly three default lines (4032 cycles) from (0,0).
    repeat (3 * 1344 - 1) step(1'b0);
    #5;
    chk("hsync_low_cycles_3_lines", 64'(hs_low_a), 64'd408);
    chk("frame_starts_small",       64'(fs_cnt_s), 64'd15);
    chk("frame_count_small",        64'(fc_b),     64'd14);

    // Frame counter wrap: preload 65535 mid-frame, then cross the next (0,0).
    step(1'b1);
    repeat (300) step(1'b0);
    #5;
    chk("fc_wrap_b", 64'(fc_b), 64'd0);
    chk("fc_wrap_c", 64'(fc_c), 64'd0);

    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
